io_read_arbiter: RTL
====================

Name: io_read_arbiter

Overview:
- Sequences and shares the CPU I/O read data path between up to NREQ responders: the port block (#FE/#FF/Kempston), AY, DivMMC, ULAplus and similar.
- Samples responder `active`/`data` pairs at a fixed delay after an I/O read starts, then grants one winner by fixed priority.
- Holds the granted byte stable until the read cycle ends, and flags collisions.
- Sits between the responders and the top-level CPU data-bus driver.

Parameters:
- NREQ, 4, number of responders; index 0 has the highest priority. Legal range 1..8.
- SAMPLE_DELAY, 2, clk28 cycles from read-cycle detection to the sampling point. Legal range 1..15.

Ports:
- clk28  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ioreq  in  1  registered CPU IORQ, active-high
- rd  in  1  registered CPU RD, active-high
- m1  in  1  registered CPU M1, active-high; ioreq&m1 is an interrupt acknowledge
- req_active  in  NREQ  per-responder "I drive data" flag
- req_data  in  8*NREQ  responder bytes; responder i occupies bits [8i+7:8i]
- d_out  out  8  arbitrated read byte
- d_out_active  out  1  arbiter drives d_out onto the CPU bus
- grant  out  NREQ  one-hot winner, held while in HOLD
- collision  out  1  one-cycle pulse when more than one responder was active at the sample point
- coll_count  out  8  saturating collision count (optional feature; reads 0 when the feature is off)

Behaviour:
- Reset values: state IDLE, d_out=8'h00, d_out_active=0, grant=0, collision=0, coll_count=0, delay counter=0.
- Reset asserted mid-cycle forces the reset values immediately. After rst deasserts, no grant is issued until a fresh ioreq&rd&!m1 rising condition is seen in IDLE.
- cycle_on = ioreq & rd & !m1.
- IDLE:
  - cycle_on=1 -> load cnt=SAMPLE_DELAY-1, go WAIT.
  - ioreq&m1 (INTA) is ignored; the arbiter stays in IDLE.
- WAIT:
  - cycle_on=0 -> IDLE (aborted cycle). No outputs change; no collision pulse.
  - Else, cnt!=0 -> decrement cnt.
  - Else, cnt==0 -> sample, go HOLD.
- Sample (the single registered edge on leaving WAIT):
  - Winner = lowest index i with req_active[i]=1.
  - grant = one-hot of the winner; d_out = req_data[winner]; d_out_active=1.
  - No responder active -> grant=0, d_out_active=0, d_out holds its previous value. The floating-bus/#FF logic is outside this block.
  - popcount(req_active)>1 -> collision=1 for exactly one cycle, in the same cycle grant appears.
- HOLD:
  - grant, d_out and d_out_active stay frozen; later changes on req_active/req_data are ignored.
  - cycle_on=0 -> RELEASE.
- RELEASE (one cycle):
  - d_out_active=0, grant=0; d_out keeps its last value.
  - Next state is IDLE, even if cycle_on is already 1 again. A back-to-back read is detected on the following IDLE cycle.
- Latency: cycle_on rising in IDLE -> grant/d_out_active valid after SAMPLE_DELAY+1 clk28 edges.
- Release latency: cycle_on falling -> d_out_active low after 2 edges (HOLD->RELEASE, then registered low).
- NREQ=1: the collision output is constant 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: IO_ARB_STATS_EN.
- Defined: an 8-bit coll_count register increments on every collision pulse and saturates at 8'hFF. It is cleared only by rst.
- Undefined: coll_count is tied to 8'h00 and no counter logic is synthesised. The collision pulse is unaffected.

Decomposition:
- Package `common` gains:
  - typedef enum logic [1:0] io_arb_state_t {IO_ARB_IDLE, IO_ARB_WAIT, IO_ARB_HOLD, IO_ARB_RELEASE};
  - localparam IO_ARB_NREQ_MAX = 8.
- Sub-module prio_onehot (parameter N): combinational lowest-index-first one-hot encoder.
  - Outputs: onehot[N-1:0], any, multi (more than one bit set).
  - Instantiated once inside io_read_arbiter.

Test Plan:
- NREQ=4, SAMPLE_DELAY=2; req_active=4'b0100, req_data[23:16]=8'hA5; cycle_on held 6 cycles -> grant=4'b0100 and d_out=8'hA5 on the 3rd edge; d_out_active=1; collision=0; d_out_active low 2 edges after rd falls.
- req_active=4'b1010 with bytes 8'h11 (index 1) and 8'h22 (index 3) -> grant=4'b0010, d_out=8'h11, one-cycle collision pulse; with IO_ARB_STATS_EN, coll_count goes 0 -> 1.
- rd drops 1 cycle after rising (abort in WAIT) -> d_out_active, grant and collision never assert; state returns to IDLE.
- ioreq&m1 INTA with req_active=4'b0001 -> no grant, d_out_active stays 0.
- Samples with req_active=0 -> d_out_active=0, grant=0, d_out unchanged from the previous grant. Then change req_data during HOLD after a valid grant -> d_out stays frozen.
- Assert rst while in HOLD -> all outputs zero asynchronously. With IO_ARB_STATS_EN: 300 collisions -> coll_count saturates at 8'hFF.

Source files
------------

// File: rtl/common.sv
// Shared definitions for the I/O read-path blocks.
// io_read_arbiter uses the FSM state type and the responder-count limit below.
package common;

    // Upper bound on the number of responders sharing the CPU read path
    localparam int IO_ARB_NREQ_MAX = 8;

    // Read-arbiter sequencing states
    typedef enum logic [1:0] {
        IO_ARB_IDLE    = 2'd0,
        IO_ARB_WAIT    = 2'd1,
        IO_ARB_HOLD    = 2'd2,
        IO_ARB_RELEASE = 2'd3
    } io_arb_state_t;

endpackage

// File: rtl/prio_onehot.sv
// Lowest-index-first priority encoder.
// onehot marks the first set request bit, any = at least one request,
// multi = more than one request bit set. Purely combinational.
module prio_onehot #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic         any,
    output logic         multi
);

    // Walk from index 0 upwards; 'seen' records whether a higher-priority bit was set
    always_comb begin
        logic seen;
        seen   = 1'b0;
        multi  = 1'b0;
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = req[i] & ~seen;
            multi     = multi | (req[i] & seen);
            seen      = seen | req[i];
        end
        any = seen;
    end

endmodule

// File: rtl/io_read_arbiter.sv
// io_read_arbiter: shares the CPU I/O read data path between NREQ responders.
// An I/O read (ioreq & rd & !m1) starts a SAMPLE_DELAY countdown; at the sample
// point the lowest-index active responder wins and its byte is held until the
// read ends. Simultaneous responders raise a one-cycle collision pulse.
// Optional feature macro: IO_ARB_STATS_EN enables the saturating coll_count
// register; without it coll_count reads 8'h00.
module io_read_arbiter
    import common::*;
#(
    parameter int NREQ         = 4,
    parameter int SAMPLE_DELAY = 2
) (
    input  logic              clk28,
    input  logic              rst,
    input  logic              ioreq,
    input  logic              rd,
    input  logic              m1,
    input  logic [NREQ-1:0]   req_active,
    input  logic [8*NREQ-1:0] req_data,
    output logic [7:0]        d_out,
    output logic              d_out_active,
    output logic [NREQ-1:0]   grant,
    output logic              collision,
    output logic [7:0]        coll_count
);

    localparam logic [3:0] CNT_LOAD = 4'(SAMPLE_DELAY - 1);

    io_arb_state_t   state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [7:0]      d_out_reg, d_out_next;
    logic            active_reg, active_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic            collision_reg, collision_next;

    logic            cycle_on;
    logic [NREQ-1:0] win_onehot;
    logic            win_any;
    logic            win_multi;
    logic [7:0]      win_data;
    logic [7:0]      masked_data [NREQ];

    assign cycle_on = ioreq & rd & ~m1;

    prio_onehot #(
        .N(NREQ)
    ) u_prio (
        .req    (req_active),
        .onehot (win_onehot),
        .any    (win_any),
        .multi  (win_multi)
    );

    // Each responder byte is gated by its one-hot grant bit, so OR-ing them selects the winner
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
        assign masked_data[gi] = req_data[8*gi +: 8] & {8{win_onehot[gi]}};
    end

    // Reduce the gated bytes into the winning byte
    always_comb begin
        win_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            win_data = win_data | masked_data[i];
        end
    end

    // State, counter and output registers; reset clears everything immediately
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_reg     <= IO_ARB_IDLE;
            cnt_reg       <= 4'd0;
            d_out_reg     <= 8'h00;
            active_reg    <= 1'b0;
            grant_reg     <= '0;
            collision_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            d_out_reg     <= d_out_next;
            active_reg    <= active_next;
            grant_reg     <= grant_next;
            collision_reg <= collision_next;
        end
    end

    // Next-state and output logic; outputs only change at the sample edge and in RELEASE
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        d_out_next     = d_out_reg;
        active_next    = active_reg;
        grant_next     = grant_reg;
        collision_next = 1'b0;
        case (state_reg)
            IO_ARB_IDLE: begin
                if (cycle_on) begin
                    cnt_next   = CNT_LOAD;
                    state_next = IO_ARB_WAIT;
                end
            end
            IO_ARB_WAIT: begin
                if (!cycle_on) begin
                    state_next = IO_ARB_IDLE;
                end else if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    state_next     = IO_ARB_HOLD;
                    grant_next     = win_onehot;
                    active_next    = win_any;
                    collision_next = win_multi;
                    // With no responder the last byte is kept; the floating bus is handled elsewhere
                    if (win_any) begin
                        d_out_next = win_data;
                    end
                end
            end
            IO_ARB_HOLD: begin
                if (!cycle_on) begin
                    state_next = IO_ARB_RELEASE;
                end
            end
            IO_ARB_RELEASE: begin
                active_next = 1'b0;
                grant_next  = '0;
                state_next  = IO_ARB_IDLE;
            end
            default: begin
                state_next = IO_ARB_IDLE;
            end
        endcase
    end

    assign d_out        = d_out_reg;
    assign d_out_active = active_reg;
    assign grant        = grant_reg;
    assign collision    = collision_reg;

`ifdef IO_ARB_STATS_EN
    logic [7:0] coll_count_reg;

    // Count collisions on the same edge the pulse is registered, saturating at 8'hFF
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            coll_count_reg <= 8'h00;
        end else if (collision_next && (coll_count_reg != 8'hFF)) begin
            coll_count_reg <= coll_count_reg + 8'd1;
        end
    end

    assign coll_count = coll_count_reg;
`else
    assign coll_count = 8'h00;
`endif

endmodule
